// File: rtl/uart_tx_ctrl.sv
`timescale 1ns/1ps
// uart_tx_ctrl: drains fifo_tx and serialises each byte as an 8N1/8N2 UART
// frame, LSB first, at CLKS_PER_BIT clocks per bit. It is the sole reader of
// the FIFO. It pops only after seeing a non-empty flag, waits one cycle for
// the read data, then shifts the byte out.
module uart_tx_ctrl #(
   parameter int CLKS_PER_BIT = 27,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk_3125_tx,
   input  logic                 reset,
   input  logic                 tx_en,
   input  logic                 fifo_empty,
   input  logic [DATA_BITS-1:0] fifo_dout,
   output logic                 fifo_rd_en,
   output logic                 tx,
   output logic                 busy,
   output logic                 frame_done
);

   localparam int BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_RANGE = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
   localparam int BIT_W     = (BIT_RANGE > 1) ? $clog2(BIT_RANGE) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
   localparam logic [BAUD_W-1:0] BAUD_ZERO = '0;
   localparam logic [BIT_W-1:0]  BIT_ZERO  = '0;
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
   localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_LATCH = 3'd2,
      S_START = 3'd3,
      S_DATA  = 3'd4,
      S_STOP  = 3'd5
   } state_e;

   state_e                 state_q, state_d;
   logic [BAUD_W-1:0]      baud_q, baud_d;
   logic [BIT_W-1:0]       bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   tx_q, tx_d;
   logic                   rd_en_q, rd_en_d;
   logic                   done_q, done_d;
   logic                   start_ok;

   assign start_ok   = tx_en & ~fifo_empty;
   assign fifo_rd_en = rd_en_q;
   assign tx         = tx_q;
   assign frame_done = done_q;
   assign busy       = (state_q != S_IDLE);

   // State, counters, shift register and registered outputs; reset forces an idle line at once.
   always_ff @(posedge clk_3125_tx or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         baud_q  <= BAUD_ZERO;
         bit_q   <= BIT_ZERO;
         shift_q <= '0;
         tx_q    <= 1'b1;
         rd_en_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         rd_en_q <= rd_en_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: frame sequencing plus baud/bit counting and data shifting.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      case (state_q)
         S_IDLE: begin
            baud_d = BAUD_ZERO;
            bit_d  = BIT_ZERO;
            if (start_ok) begin
               state_d = S_READ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_READ: begin
            state_d = S_LATCH;
         end
         S_LATCH: begin
            // FIFO read data is valid this cycle, one clock after the pop.
            shift_d = fifo_dout;
            state_d = S_START;
         end
         S_START: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = BAUD_ZERO;
               bit_d   = BIT_ZERO;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end
         S_DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = BAUD_ZERO;
               shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
               if (bit_q == DATA_LAST) begin
                  bit_d   = BIT_ZERO;
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_q + BIT_ONE;
               end
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end
         S_STOP: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = BAUD_ZERO;
               if (bit_q == STOP_LAST) begin
                  bit_d = BIT_ZERO;
                  // Back-to-back frames skip IDLE; the gap is just READ+LATCH.
                  if (start_ok) begin
                     state_d = S_READ;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  bit_d = bit_q + BIT_ONE;
               end
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            baud_d  = BAUD_ZERO;
            bit_d   = BIT_ZERO;
         end
      endcase
   end

   // Output decode from the next state so tx, pop strobe and frame_done come straight from flops.
   always_comb begin
      tx_d    = 1'b1;
      rd_en_d = 1'b0;
      done_d  = 1'b0;
      case (state_d)
         S_READ:  rd_en_d = 1'b1;
         S_START: tx_d    = 1'b0;
         S_DATA:  tx_d    = shift_d[0];
         default: tx_d    = 1'b1;
      endcase
      if ((state_d == S_STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST)) begin
         done_d = 1'b1;
      end else begin
         done_d = 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
`timescale 1ns/1ps
// Directed bench for uart_tx_ctrl: two instances (1 and 2 stop bits, 4 clocks
// per bit) each fed by a small registered-read FIFO model.
module tb_uart_tx_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_en;
   logic       en2 = 1'b1;

   // FIFO model for instance 1: read data registered on the edge sampling rd_en.
   logic [7:0] mem [0:255];
   logic [7:0] wr_ptr = 8'd0;
   logic [7:0] rd_ptr = 8'd0;
   logic [7:0] f_dout = 8'd0;
   int         pops   = 0;
   logic       f_empty;
   logic       rd_en1, tx1, busy1, fd1;

   // FIFO model for instance 2: holds f2_avail copies of 0x0F.
   int         f2_avail = 0;
   int         f2_pops  = 0;
   logic [7:0] f2_dout  = 8'd0;
   logic       f2_empty;
   logic       rd_en2, tx2, busy2, fd2;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] data;
      logic [9:0] exp_bits;   // {stop, d7..d0, start}
      bit         preload;    // push this and following non-preload entries first
      int         exp_steps;  // negedges from reference point to first start cycle
   } vec_t;

   vec_t vecs [0:3];

   uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1)) dut1 (
      .clk_3125_tx (clk),
      .reset       (reset),
      .tx_en       (tx_en),
      .fifo_empty  (f_empty),
      .fifo_dout   (f_dout),
      .fifo_rd_en  (rd_en1),
      .tx          (tx1),
      .busy        (busy1),
      .frame_done  (fd1)
   );

   uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(2)) dut2 (
      .clk_3125_tx (clk),
      .reset       (reset),
      .tx_en       (en2),
      .fifo_empty  (f2_empty),
      .fifo_dout   (f2_dout),
      .fifo_rd_en  (rd_en2),
      .tx          (tx2),
      .busy        (busy2),
      .frame_done  (fd2)
   );

   always #5 clk = ~clk;

   assign f_empty  = (wr_ptr == rd_ptr);
   assign f2_empty = (f2_pops >= f2_avail);

   always @(posedge clk) begin
      if (rd_en1) begin
         f_dout <= mem[rd_ptr];
         rd_ptr <= rd_ptr + 8'd1;
         pops   <= pops + 1;
      end
   end

   always @(posedge clk) begin
      if (rd_en2) begin
         f2_dout <= 8'h0F;
         f2_pops <= f2_pops + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      mem[wr_ptr] = d;
      wr_ptr      = wr_ptr + 8'd1;
   endtask

   function automatic logic get_tx(input bit sel);
      return sel ? tx2 : tx1;
   endfunction

   // Steps negedges until tx is low; steps = -1 if the bound expires.
   task automatic wait_tx_low(input bit sel, output int steps);
      steps = 0;
      do begin
         @(negedge clk);
         steps++;
      end while (get_tx(sel) !== 1'b0 && steps < 300);
      if (get_tx(sel) !== 1'b0) steps = -1;
   endtask

   // Called on the negedge of the first start cycle; ends on the negedge of the last stop cycle.
   task automatic check_frame(input string name, input bit sel, input logic [9:0] exp,
                              input int nstop, input int drop_k);
      int   nb;
      int   last;
      int   bit_err;
      int   fd_err;
      int   busy_err;
      int   k;
      logic exp_b;
      logic fd_s;
      logic busy_s;
      nb       = 9 + nstop;
      last     = nb * 4 - 1;
      fd_err   = 0;
      busy_err = 0;
      for (int b = 0; b < nb; b++) begin
         bit_err = 0;
         exp_b   = (b > 9) ? 1'b1 : exp[b];
         for (int c = 0; c < 4; c++) begin
            k = b * 4 + c;
            if (k == drop_k) tx_en = 1'b0;
            fd_s   = sel ? fd2 : fd1;
            busy_s = sel ? busy2 : busy1;
            if (get_tx(sel) !== exp_b) bit_err++;
            if (fd_s !== ((k == last) ? 1'b1 : 1'b0)) fd_err++;
            if (busy_s !== 1'b1) busy_err++;
            if (k != last) @(negedge clk);
         end
         chk($sformatf("%s bit%0d wrong-cycles", name, b), bit_err, 0);
      end
      chk($sformatf("%s frame_done wrong-cycles", name), fd_err, 0);
      chk($sformatf("%s busy wrong-cycles", name), busy_err, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int steps;
      int err;
      int p_prev;
      int j;

      vecs[0] = '{data: 8'hA5, exp_bits: 10'b1_1010_0101_0, preload: 1'b1, exp_steps: 3};
      vecs[1] = '{data: 8'h00, exp_bits: 10'b1_0000_0000_0, preload: 1'b1, exp_steps: 3};
      vecs[2] = '{data: 8'hFF, exp_bits: 10'b1_1111_1111_0, preload: 1'b0, exp_steps: 3};
      vecs[3] = '{data: 8'h55, exp_bits: 10'b1_0101_0101_0, preload: 1'b0, exp_steps: 3};

      // T1: asynchronous reset with a byte waiting in the FIFO
      reset = 1'b1;
      tx_en = 1'b1;
      #2;
      reset = 1'b0;
      push(8'h3C);
      #1;
      chk("reset immediate {tx,busy,rd_en,done}", {tx1, busy1, rd_en1, fd1}, 4'b1000);
      err = 0;
      repeat (20) begin
         @(negedge clk);
         if ({tx1, busy1, rd_en1, fd1} !== 4'b1000) err++;
      end
      chk("reset hold bad-cycles", err, 0);
      chk("reset no pop", pops, 0);
      reset = 1'b1;
      wait_tx_low(1'b0, steps);
      chk("post-reset latency", steps, 3);
      check_frame("frame 3C", 1'b0, 10'b1_0011_1100_0, 1, -1);
      chk("3C pops", pops, 1);
      @(negedge clk);
      chk("3C idle busy", busy1, 1'b0);

      // T2/T3: table of frames, single byte then three back-to-back
      p_prev = pops;
      for (int i = 0; i < 4; i++) begin
         if (vecs[i].preload) begin
            j = i;
            do begin
               push(vecs[j].data);
               j++;
            end while (j < 4 && !vecs[j].preload);
         end
         wait_tx_low(1'b0, steps);
         chk($sformatf("vec%0d gap", i), steps, vecs[i].exp_steps);
         check_frame($sformatf("vec%0d", i), 1'b0, vecs[i].exp_bits, 1, -1);
         chk($sformatf("vec%0d pop count", i), pops - p_prev, 1);
         p_prev = pops;
         if (i == 3 || vecs[i + 1].preload) begin
            @(negedge clk);
            chk($sformatf("vec%0d idle {tx,busy}", i), {tx1, busy1}, 2'b10);
         end
      end

      // T4: tx_en low blocks pops; dropping it mid-frame finishes that frame only
      tx_en = 1'b0;
      push(8'h11);
      err = 0;
      repeat (100) begin
         @(negedge clk);
         if ({tx1, busy1, rd_en1} !== 3'b100) err++;
      end
      chk("tx_en=0 hold bad-cycles", err, 0);
      chk("tx_en=0 no pop", pops - p_prev, 0);
      push(8'h22);
      tx_en = 1'b1;
      wait_tx_low(1'b0, steps);
      chk("11 latency", steps, 3);
      check_frame("frame 11", 1'b0, 10'b1_0001_0001_0, 1, 20);
      err = 0;
      repeat (50) begin
         @(negedge clk);
         if ({tx1, busy1, rd_en1} !== 3'b100) err++;
      end
      chk("after drop bad-cycles", err, 0);
      chk("after drop pop count", pops - p_prev, 1);
      tx_en = 1'b1;
      wait_tx_low(1'b0, steps);
      chk("22 latency", steps, 3);
      check_frame("frame 22", 1'b0, 10'b1_0010_0010_0, 1, -1);
      chk("22 pop count", pops - p_prev, 2);
      @(negedge clk);
      p_prev = pops;

      // T5: reset during data bit 3, popped byte is discarded
      push(8'hF7);
      wait_tx_low(1'b0, steps);
      chk("F7 latency", steps, 3);
      repeat (17) @(negedge clk);
      chk("F7 bit3 low", tx1, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      chk("mid-frame reset {tx,busy,rd_en,done}", {tx1, busy1, rd_en1, fd1}, 4'b1000);
      repeat (3) @(negedge clk);
      chk("mid-frame reset hold {tx,busy}", {tx1, busy1}, 2'b10);
      push(8'h81);
      reset = 1'b1;
      wait_tx_low(1'b0, steps);
      chk("81 latency", steps, 3);
      check_frame("frame 81", 1'b0, 10'b1_1000_0001_0, 1, -1);
      chk("81 pop count", pops - p_prev, 2);
      @(negedge clk);
      chk("81 idle busy", busy1, 1'b0);

      // T6: two stop bits on the second instance
      chk("dut2 idle before", {tx2, busy2, f2_pops[3:0]}, 6'b10_0000);
      f2_avail = 1;
      wait_tx_low(1'b1, steps);
      chk("0F latency", steps, 3);
      check_frame("frame 0F 2stop", 1'b1, 10'b1_0000_1111_0, 2, -1);
      chk("0F pop count", f2_pops, 1);
      @(negedge clk);
      chk("0F idle {tx,busy}", {tx2, busy2}, 2'b10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
